// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-op pipeline: opcode encoding and widths.
// Opcodes 10-13 are only implemented when LOGIC_OP_ACC_EN is defined.
package logic_op_pkg;

   localparam int unsigned OP_W          = 4;
   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [OP_W-1:0] {
      OP_AND     = 4'd0,
      OP_OR      = 4'd1,
      OP_NAND    = 4'd2,
      OP_NOR     = 4'd3,
      OP_XOR     = 4'd4,
      OP_XNOR    = 4'd5,
      OP_NOT_A   = 4'd6,
      OP_PASS_A  = 4'd7,
      OP_LAND    = 4'd8,
      OP_LOR     = 4'd9,
      OP_ACC_AND = 4'd10,
      OP_ACC_OR  = 4'd11,
      OP_ACC_XOR = 4'd12,
      OP_ACC_CLR = 4'd13
   } op_e;

endpackage

// File: rtl/logic_op_pipe_if.sv
// Valid/ready request and result channels of the logic-op pipeline.
interface logic_op_pipe_if #(
   parameter int unsigned WIDTH = logic_op_pkg::DEFAULT_WIDTH
) ();

   logic                          in_valid;
   logic                          in_ready;
   logic [logic_op_pkg::OP_W-1:0] in_op;
   logic [WIDTH-1:0]              in_a;
   logic [WIDTH-1:0]              in_b;
   logic                          out_valid;
   logic                          out_ready;
   logic [WIDTH-1:0]              out_data;
   logic                          out_err;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data, out_err
   );

endinterface

// File: rtl/logic_op_alu.sv
// Combinational opcode/operand evaluation between the two pipeline stages.
// With LOGIC_OP_ACC_EN defined, the accumulator ops read acc and raise acc_we.
module logic_op_alu
   import logic_op_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef LOGIC_OP_ACC_EN
   input  logic [WIDTH-1:0] acc,
   output logic             acc_we,
`endif
   output logic [WIDTH-1:0] result,
   output logic             err
);

   // Opcode decode; anything not listed yields zero data with err set
   always_comb begin
      result = '0;
      err    = 1'b0;
`ifdef LOGIC_OP_ACC_EN
      acc_we = 1'b0;
`endif
      case (op)
         OP_AND:    result = a & b;
         OP_OR:     result = a | b;
         OP_NAND:   result = ~(a & b);
         OP_NOR:    result = ~(a | b);
         OP_XOR:    result = a ^ b;
         OP_XNOR:   result = ~(a ^ b);
         OP_NOT_A:  result = ~a;
         OP_PASS_A: result = a;
         OP_LAND:   result = WIDTH'((|a) && (|b));
         OP_LOR:    result = WIDTH'((|a) || (|b));
`ifdef LOGIC_OP_ACC_EN
         OP_ACC_AND: begin
            result = acc & a;
            acc_we = 1'b1;
         end
         OP_ACC_OR: begin
            result = acc | a;
            acc_we = 1'b1;
         end
         OP_ACC_XOR: begin
            result = acc ^ a;
            acc_we = 1'b1;
         end
         OP_ACC_CLR: begin
            result = '0;
            acc_we = 1'b1;
         end
`endif
         default:   err = 1'b1;
      endcase
   end

endmodule

// File: rtl/logic_op_pipe.sv
// Two-stage valid/ready pipeline: S1 holds the request, S2 holds the result.
// Optional accumulator opcodes are enabled by defining LOGIC_OP_ACC_EN.
module logic_op_pipe
   import logic_op_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input logic            clk,
   input logic            rst,
   logic_op_pipe_if.slave bus
);

   logic             s1_valid;
   logic [OP_W-1:0]  s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;

   logic             s2_valid;
   logic [WIDTH-1:0] s2_data;
   logic             s2_err;

   logic [WIDTH-1:0] alu_result;
   logic             alu_err;

   logic             s2_open_c;
   logic             s2_load_c;
   logic             in_ready_c;
   logic             s1_load_c;

   // S2 can take new data when empty or being drained this cycle
   assign s2_open_c  = !s2_valid || bus.out_ready;
   assign s2_load_c  = s1_valid && s2_open_c;
   assign in_ready_c = !s1_valid || s2_open_c;
   assign s1_load_c  = bus.in_valid && in_ready_c;

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = s2_valid;
   assign bus.out_data  = s2_data;
   assign bus.out_err   = s2_err;

`ifdef LOGIC_OP_ACC_EN
   logic [WIDTH-1:0] acc;
   logic             alu_acc_we;

   // Accumulator updates only when its op moves into S2, so a stall never re-applies it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (s2_load_c && alu_acc_we) begin
         acc <= alu_result;
      end
   end
`endif

   logic_op_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .op     (s1_op),
      .a      (s1_a),
      .b      (s1_b),
`ifdef LOGIC_OP_ACC_EN
      .acc    (acc),
      .acc_we (alu_acc_we),
`endif
      .result (alu_result),
      .err    (alu_err)
   );

   // Stage 1: capture accepted request; empty out when handed to S2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (s1_load_c) begin
         s1_valid <= 1'b1;
         s1_op    <= bus.in_op;
         s1_a     <= bus.in_a;
         s1_b     <= bus.in_b;
      end else if (s2_load_c) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: capture ALU result; hold stable until consumed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_err   <= 1'b0;
      end else if (s2_load_c) begin
         s2_valid <= 1'b1;
         s2_data  <= alu_result;
         s2_err   <= alu_err;
      end else if (bus.out_ready) begin
         s2_valid <= 1'b0;
      end
   end

endmodule
